// File: rtl/riscv_control_unit.sv
// Decode-stage control unit for a 5-stage RV32I pipeline: main decoder plus
// ALU decoder, with every control registered for the ID/EX boundary.
module riscv_control_unit (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  output logic       regwrite_d,
  output logic [1:0] resultsrc_d,
  output logic       memwrite_d,
  output logic       jump_d,
  output logic       branch_d,
  output logic [2:0] alucontrol_d,
  output logic       alusrc_d,
  output logic [1:0] immsrc_d
);

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_IALU = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  localparam logic [1:0] ALUOP_ADD  = 2'b00;
  localparam logic [1:0] ALUOP_SUB  = 2'b01;
  localparam logic [1:0] ALUOP_FUNC = 2'b10;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  logic       regwrite_c;
  logic [1:0] resultsrc_c;
  logic       memwrite_c;
  logic       jump_c;
  logic       branch_c;
  logic [1:0] aluop_c;
  logic       alusrc_c;
  logic [1:0] immsrc_c;
  logic [2:0] alucontrol_c;

  // Packed control word: {regwrite, resultsrc, memwrite, jump, branch,
  // alucontrol, alusrc, immsrc}
  logic [11:0] ctrl_d;
  logic [11:0] ctrl_q;

  always_comb begin
    regwrite_c  = 1'b0;
    resultsrc_c = 2'b00;
    memwrite_c  = 1'b0;
    jump_c      = 1'b0;
    branch_c    = 1'b0;
    aluop_c     = ALUOP_ADD;
    alusrc_c    = 1'b0;
    immsrc_c    = 2'b00;
    case (op)
      OP_LW: begin
        regwrite_c  = 1'b1;
        alusrc_c    = 1'b1;
        resultsrc_c = 2'b01;
      end
      OP_SW: begin
        immsrc_c   = 2'b01;
        alusrc_c   = 1'b1;
        memwrite_c = 1'b1;
      end
      OP_R: begin
        regwrite_c = 1'b1;
        aluop_c    = ALUOP_FUNC;
      end
      OP_IALU: begin
        regwrite_c = 1'b1;
        alusrc_c   = 1'b1;
        aluop_c    = ALUOP_FUNC;
      end
      OP_BEQ: begin
        immsrc_c = 2'b10;
        branch_c = 1'b1;
        aluop_c  = ALUOP_SUB;
      end
      OP_JAL: begin
        regwrite_c  = 1'b1;
        immsrc_c    = 2'b11;
        resultsrc_c = 2'b10;
        jump_c      = 1'b1;
      end
      default: ;
    endcase
  end

  // funct fields are only examined under ALUOP_FUNC, so unknowns on them
  // cannot leak into loads, stores, branches or jumps.
  always_comb begin
    alucontrol_c = ALU_ADD;
    case (aluop_c)
      ALUOP_SUB: alucontrol_c = ALU_SUB;
      ALUOP_FUNC: begin
        case (funct3)
          3'b000: begin
            // Only R-type (op[5]=1) can select sub; addi ignores bit 30.
            if (op[5] && funct7_5) alucontrol_c = ALU_SUB;
            else                   alucontrol_c = ALU_ADD;
          end
          3'b010:  alucontrol_c = ALU_SLT;
          3'b110:  alucontrol_c = ALU_OR;
          3'b111:  alucontrol_c = ALU_AND;
          default: alucontrol_c = ALU_ADD;
        endcase
      end
      default: alucontrol_c = ALU_ADD;
    endcase
  end

  always_comb begin
    ctrl_d = {regwrite_c, resultsrc_c, memwrite_c, jump_c, branch_c,
              alucontrol_c, alusrc_c, immsrc_c};
  end

  always_ff @(posedge clk) begin
    if (rst) ctrl_q <= 12'd0;
    else     ctrl_q <= ctrl_d;
  end

  assign regwrite_d   = ctrl_q[11];
  assign resultsrc_d  = ctrl_q[10:9];
  assign memwrite_d   = ctrl_q[8];
  assign jump_d       = ctrl_q[7];
  assign branch_d     = ctrl_q[6];
  assign alucontrol_d = ctrl_q[5:3];
  assign alusrc_d     = ctrl_q[2];
  assign immsrc_d     = ctrl_q[1:0];

endmodule

// File: tb/tb_riscv_control_unit.sv
// Directed bench for riscv_control_unit: expected control words are queued
// when each instruction is driven and compared after the registering edge.
module tb_riscv_control_unit;

  logic       clk;
  logic       rst;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7_5;
  logic       regwrite_d;
  logic [1:0] resultsrc_d;
  logic       memwrite_d;
  logic       jump_d;
  logic       branch_d;
  logic [2:0] alucontrol_d;
  logic       alusrc_d;
  logic [1:0] immsrc_d;

  int n_pass = 0;
  int n_total = 0;
  logic [11:0] exp_q[$];
  string       tag_q[$];

  riscv_control_unit dut (
    .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7_5(funct7_5),
    .regwrite_d(regwrite_d), .resultsrc_d(resultsrc_d), .memwrite_d(memwrite_d),
    .jump_d(jump_d), .branch_d(branch_d), .alucontrol_d(alucontrol_d),
    .alusrc_d(alusrc_d), .immsrc_d(immsrc_d)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Field order: regwrite, resultsrc, memwrite, jump, branch, alucontrol, alusrc, immsrc
  function automatic logic [11:0] pack(input logic rw, input logic [1:0] rs,
                                       input logic mw, input logic j, input logic b,
                                       input logic [2:0] ac, input logic as,
                                       input logic [1:0] is);
    return {rw, rs, mw, j, b, ac, as, is};
  endfunction

  task automatic step(input string tag, input logic r, input logic [6:0] o,
                      input logic [2:0] f3, input logic f7, input logic [11:0] expv);
    logic [11:0] obs;
    logic [11:0] want;
    string       t;
    @(negedge clk);
    rst = r; op = o; funct3 = f3; funct7_5 = f7;
    exp_q.push_back(expv);
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
    obs  = {regwrite_d, resultsrc_d, memwrite_d, jump_d, branch_d,
            alucontrol_d, alusrc_d, immsrc_d};
    want = exp_q.pop_front();
    t    = tag_q.pop_front();
    n_total++;
    assert (obs === want) n_pass++;
    else $error("FAIL %s: observed %b required %b", t, obs, want);
    $display("txn %-12s rst=%b op=%b f3=%b f7_5=%b -> ctrl=%b", t, r, o, f3, f7, obs);
  endtask

  initial begin
    rst = 1'b1; op = 7'd0; funct3 = 3'd0; funct7_5 = 1'b0;
    step("reset",      1'b1, 7'b0000011, 3'b000, 1'b0, 12'd0);
    step("lw",         1'b0, 7'b0000011, 3'bxxx, 1'bx, pack(1, 2'b01, 0, 0, 0, 3'b000, 1, 2'b00));
    step("sw",         1'b0, 7'b0100011, 3'bxxx, 1'bx, pack(0, 2'b00, 1, 0, 0, 3'b000, 1, 2'b01));
    step("add",        1'b0, 7'b0110011, 3'b000, 1'b0, pack(1, 2'b00, 0, 0, 0, 3'b000, 0, 2'b00));
    step("sub",        1'b0, 7'b0110011, 3'b000, 1'b1, pack(1, 2'b00, 0, 0, 0, 3'b001, 0, 2'b00));
    step("slt",        1'b0, 7'b0110011, 3'b010, 1'b0, pack(1, 2'b00, 0, 0, 0, 3'b101, 0, 2'b00));
    step("or",         1'b0, 7'b0110011, 3'b110, 1'b0, pack(1, 2'b00, 0, 0, 0, 3'b011, 0, 2'b00));
    step("and",        1'b0, 7'b0110011, 3'b111, 1'b0, pack(1, 2'b00, 0, 0, 0, 3'b010, 0, 2'b00));
    step("r_f3_001",   1'b0, 7'b0110011, 3'b001, 1'b1, pack(1, 2'b00, 0, 0, 0, 3'b000, 0, 2'b00));
    step("beq",        1'b0, 7'b1100011, 3'bxxx, 1'bx, pack(0, 2'b00, 0, 0, 1, 3'b001, 0, 2'b10));
    step("jal",        1'b0, 7'b1101111, 3'b111, 1'b1, pack(1, 2'b10, 0, 1, 0, 3'b000, 0, 2'b11));
    step("addi_f7",    1'b0, 7'b0010011, 3'b000, 1'b1, pack(1, 2'b00, 0, 0, 0, 3'b000, 1, 2'b00));
    step("slti",       1'b0, 7'b0010011, 3'b010, 1'b0, pack(1, 2'b00, 0, 0, 0, 3'b101, 1, 2'b00));
    step("andi",       1'b0, 7'b0010011, 3'b111, 1'b1, pack(1, 2'b00, 0, 0, 0, 3'b010, 1, 2'b00));
    step("illegal",    1'b0, 7'b1111111, 3'b010, 1'b1, 12'd0);
    step("lw_again",   1'b0, 7'b0000011, 3'b110, 1'b1, pack(1, 2'b01, 0, 0, 0, 3'b000, 1, 2'b00));
    step("mid_reset",  1'b1, 7'b0110011, 3'b000, 1'b1, 12'd0);
    step("post_reset", 1'b0, 7'b1101111, 3'b000, 1'b0, pack(1, 2'b10, 0, 1, 0, 3'b000, 0, 2'b11));
    step("illegal_0",  1'b0, 7'b0000000, 3'b000, 1'b0, 12'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
